piso_serializer: RTL

//  Parallel-in, serial-out stage feeding the 1-bit serial pipeline (shift-register chain).

---
 rtl/piso_serializer_pkg.sv | 16 +
 rtl/piso_serializer_bit_counter.sv | 38 +++
 rtl/piso_serializer.sv | 108 ++++++++++
 3 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer:
// FSM state encodings, the supported word-width ceiling and a counter-width helper.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int unsigned MAX_WIDTH = 32;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Saturating bit-index counter with synchronous clear and terminal-count flag.
module bit_counter #(
    parameter int unsigned LIMIT = 7,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tc_o    = (count_q == CNT_W'(LIMIT));
    assign count_o = count_q;

    // Holds at LIMIT rather than wrapping; clear takes priority over counting.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !tc_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out stage: takes a WIDTH-bit word over valid/ready and emits it
// one bit per clock with first/last framing flags; back-to-back words leave no gap.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b0,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             serial_first,
    output logic             serial_last,
    output logic             busy
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] count;
    logic             tc;
    logic             accept;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             first_q, first_d;
    logic             last_q, last_d;

    // Counter is cleared on every accept and on the last bit, so it never wraps.
    bit_counter #(
        .LIMIT (WIDTH - 1),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (accept || tc),
        .en_i    (state_q == ST_SHIFT),
        .count_o (count),
        .tc_o    (tc)
    );

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_SHIFT) && tc);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SHIFT;
            ST_SHIFT: if (tc)     state_d = accept ? ST_SHIFT : ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    // Output flops are loaded from next-state values so every flag lines up with its bit.
    always_comb begin
        shreg_d = shreg_q;
        if (accept) begin
            shreg_d = in_data;
        end else if (state_q == ST_SHIFT) begin
            shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
        end
        valid_d = (state_d == ST_SHIFT);
        out_d   = IDLE_LEVEL;
        if (valid_d) begin
            out_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
        end
        first_d = accept;
        last_d  = (state_q == ST_SHIFT) && !tc && (count == CNT_W'(WIDTH - 2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= IDLE_LEVEL;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign serial_out   = out_q;
    assign serial_valid = valid_q;
    assign serial_first = first_q;
    assign serial_last  = last_q;
    assign busy         = valid_q;

endmodule
